qam_mapper_controller: RTL and testbench

//  Transmit-side counterpart of the QAM demapper path: reads packed data words from an input FIFO,

---
 rtl/qam_pkg.sv | 39 +++
 rtl/qam16_gray_map.sv | 14 +
 rtl/qam_mapper_controller.sv | 109 ++++++++++
 tb/tb_qam_mapper_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared 16-QAM definitions: FSM encodings, I/Q level constants, Gray-to-level map.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package qam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_SEND  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Signed 3-bit amplitude level on one axis
  typedef logic [2:0] level_t;

  localparam level_t L_M3   = 3'b101;  // -3
  localparam level_t L_M1   = 3'b111;  // -1
  localparam level_t L_P1   = 3'b001;  // +1
  localparam level_t L_P3   = 3'b011;  // +3
  localparam level_t L_ZERO = 3'b000;  // idle value when no symbol is presented

  typedef struct packed {
    level_t i;
    level_t q;
  } sym_t;

  // Gray-coded bit pair to amplitude; the demapper slicer inverts this same table
  function automatic level_t gray2level(input logic [1:0] g);
    level_t lvl;
    case (g)
      2'b00:   lvl = L_M3;
      2'b01:   lvl = L_M1;
      2'b11:   lvl = L_P1;
      default: lvl = L_P3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam16_gray_map.sv
// Maps one 4-bit group to a 16-QAM I/Q symbol; upper bit pair drives I, lower pair drives Q.
// Latency: purely combinational.
// Backpressure: none; the caller holds the nibble stable while a symbol is stalled.
module qam16_gray_map
  import qam_pkg::*;
(
  input  logic [3:0] nibble_i,
  output sym_t       sym_o
);

  assign sym_o.i = gray2level(nibble_i[3:2]);
  assign sym_o.q = gray2level(nibble_i[1:0]);

endmodule

// File: rtl/qam_mapper_controller.sv
// Fetches FIFO words, emits DATA_W/4 Gray-mapped 16-QAM symbols per word MS nibble first, pulses complete per frame.
// Latency: read_enable in cycle t -> first symbol valid in cycle t+2; at least 2 idle cycles between words.
// Backpressure: sym_ready low freezes the presented symbol and the FSM; no new read until the word drains.
module qam_mapper_controller
  import qam_pkg::*;
#(
  parameter int DATA_W    = 8,   // multiple of 4
  parameter int FRAME_LEN = 16
) (
  input  logic              dclk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              rdempty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              read_enable_o,
  input  logic              sym_ready_i,
  output logic              sym_valid_o,
  output logic [2:0]        sym_i_o,
  output logic [2:0]        sym_q_o,
  output logic              available_o,
  output logic              complete_o,
  output logic [1:0]        state_o
);

  localparam int NIBS   = DATA_W / 4;
  localparam int NIB_W  = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int WCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [NIB_W-1:0]  LAST_NIB  = NIB_W'(NIBS - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_LEN - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [NIB_W-1:0]    nib_cnt_q, nib_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  sym_t                head_sym;

  // The mapper always looks at the top nibble; advancing a symbol is a left shift
  qam16_gray_map u_map (
    .nibble_i (shreg_q[DATA_W-1 -: 4]),
    .sym_o    (head_sym)
  );

  // Next-state, datapath updates and the FIFO read strobe
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    nib_cnt_d     = nib_cnt_q;
    word_cnt_d    = word_cnt_q;
    read_enable_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by reset so no read is requested while the block is held in reset
        if (enable_i && !rdempty_i && !reset_i) begin
          read_enable_o = 1'b1;
          state_d       = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // FIFO data arrives one cycle after the read strobe
        shreg_d   = fifo_data_i;
        nib_cnt_d = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (sym_ready_i) begin
          shreg_d = shreg_q << 4;
          if (nib_cnt_q == LAST_NIB) begin
            if (word_cnt_q == LAST_WORD) begin
              state_d = ST_DONE;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
              state_d    = ST_IDLE;
            end
          end else begin
            nib_cnt_d = nib_cnt_q + 1'b1;
          end
        end
      end
      default: begin  // ST_DONE: frame boundary, counter wraps here only
        word_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partially sent word
  always_ff @(posedge dclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      nib_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      nib_cnt_q  <= nib_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Outputs decode registered state only, so they fall back asynchronously on reset
  assign available_o = (state_q == ST_SEND);
  assign sym_valid_o = available_o;
  assign sym_i_o     = sym_valid_o ? head_sym.i : L_ZERO;
  assign sym_q_o     = sym_valid_o ? head_sym.q : L_ZERO;
  assign complete_o  = (state_q == ST_DONE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_qam_mapper_controller.sv
// Directed bench for qam_mapper_controller with DATA_W=8, FRAME_LEN=2.
// Table of words with hand-computed symbol pairs, then stall, enable-drop and mid-word reset sequences.
// A behavioural FIFO returns mem[] entries one cycle after each read strobe.
module tb_qam_mapper_controller;

  logic       dclk = 1'b1;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       rdempty = 1'b0;
  logic       sym_ready = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       read_enable;
  logic       sym_valid;
  logic [2:0] sym_i;
  logic [2:0] sym_q;
  logic       available;
  logic       complete;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int rd_idx = 0;
  logic [7:0] mem [8];

  typedef struct {
    logic [7:0] data;
    logic [2:0] i0, q0, i1, q1;
    logic       cmpl;
  } vec_t;
  vec_t tbl [4];

  qam_mapper_controller #(.DATA_W(8), .FRAME_LEN(2)) dut (
    .dclk_i        (dclk),
    .reset_i       (reset),
    .enable_i      (enable),
    .rdempty_i     (rdempty),
    .fifo_data_i   (fifo_data),
    .read_enable_o (read_enable),
    .sym_ready_i   (sym_ready),
    .sym_valid_o   (sym_valid),
    .sym_i_o       (sym_i),
    .sym_q_o       (sym_q),
    .available_o   (available),
    .complete_o    (complete),
    .state_o       (state)
  );

  always #5 dclk = ~dclk;

  // FIFO model: one-cycle read latency
  always @(posedge dclk) begin
    if (read_enable && rd_idx < 8) begin
      fifo_data <= mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge dclk);
    #1;
  endtask

  task automatic wait_rd(input string name);
    int k;
    k = 0;
    while (read_enable !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    chk(name, {7'd0, read_enable}, 8'd1);
  endtask

  task automatic run_word(input vec_t v, input string tag);
    wait_rd({tag, " read"});
    step();
    chk({tag, " fetch state"}, {6'd0, state}, 8'd1);
    chk({tag, " fetch valid"}, {7'd0, sym_valid}, 8'd0);
    chk({tag, " fetch rd"}, {7'd0, read_enable}, 8'd0);
    step();
    chk({tag, " send state"}, {6'd0, state}, 8'd2);
    chk({tag, " s0 valid"}, {7'd0, sym_valid}, 8'd1);
    chk({tag, " s0 avail"}, {7'd0, available}, 8'd1);
    chk({tag, " s0 i"}, {5'd0, sym_i}, {5'd0, v.i0});
    chk({tag, " s0 q"}, {5'd0, sym_q}, {5'd0, v.q0});
    step();
    chk({tag, " s1 valid"}, {7'd0, sym_valid}, 8'd1);
    chk({tag, " s1 i"}, {5'd0, sym_i}, {5'd0, v.i1});
    chk({tag, " s1 q"}, {5'd0, sym_q}, {5'd0, v.q1});
    step();
    chk({tag, " end complete"}, {7'd0, complete}, {7'd0, v.cmpl});
    chk({tag, " end state"}, {6'd0, state}, v.cmpl ? 8'd3 : 8'd0);
    chk({tag, " end valid"}, {7'd0, sym_valid}, 8'd0);
  endtask

  initial begin
    // B4 = 10 11 | 01 00 ; 1E = 00 01 | 11 10 ; 72 = 01 11 | 00 10 ; D9 = 11 01 | 10 01
    tbl[0] = '{data: 8'hB4, i0: 3'b011, q0: 3'b001, i1: 3'b111, q1: 3'b101, cmpl: 1'b0};
    tbl[1] = '{data: 8'h1E, i0: 3'b101, q0: 3'b111, i1: 3'b001, q1: 3'b011, cmpl: 1'b1};
    tbl[2] = '{data: 8'h72, i0: 3'b111, q0: 3'b001, i1: 3'b101, q1: 3'b011, cmpl: 1'b0};
    tbl[3] = '{data: 8'hD9, i0: 3'b001, q0: 3'b111, i1: 3'b011, q1: 3'b111, cmpl: 1'b1};
    for (int k = 0; k < 4; k++) mem[k] = tbl[k].data;
    mem[4] = 8'hB4;  // stall sequence
    mem[5] = 8'hC3;  // enable dropped after fetch
    mem[6] = 8'h5A;  // interrupted by reset
    mem[7] = 8'h0F;  // fresh word after reset

    // Reset values while reset is held
    #1;
    chk("rst state", {6'd0, state}, 8'd0);
    chk("rst rd", {7'd0, read_enable}, 8'd0);
    chk("rst valid", {7'd0, sym_valid}, 8'd0);
    chk("rst i", {5'd0, sym_i}, 8'd0);
    chk("rst q", {5'd0, sym_q}, 8'd0);
    chk("rst avail", {7'd0, available}, 8'd0);
    chk("rst complete", {7'd0, complete}, 8'd0);
    #14;
    reset = 1'b0;
    #1;
    chk("post-rst rd", {7'd0, read_enable}, 8'd1);
    chk("post-rst state", {6'd0, state}, 8'd0);

    // Table: back-to-back words, complete after every second word
    for (int e = 0; e < 4; e++) run_word(tbl[e], $sformatf("vec%0d", e));

    // Stall on the first symbol of B4
    sym_ready = 1'b0;
    wait_rd("stall read");
    step();
    step();
    chk("stall s0 i", {5'd0, sym_i}, 8'h03);
    chk("stall s0 q", {5'd0, sym_q}, 8'h01);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall hold valid", {7'd0, sym_valid}, 8'd1);
      chk("stall hold i", {5'd0, sym_i}, 8'h03);
      chk("stall hold q", {5'd0, sym_q}, 8'h01);
      chk("stall no read", {7'd0, read_enable}, 8'd0);
      chk("stall state", {6'd0, state}, 8'd2);
    end
    sym_ready = 1'b1;
    step();
    chk("stall s1 i", {5'd0, sym_i}, 8'h07);
    chk("stall s1 q", {5'd0, sym_q}, 8'h05);
    step();
    chk("stall end state", {6'd0, state}, 8'd0);
    chk("stall end complete", {7'd0, complete}, 8'd0);

    // Enable dropped after fetch: word completes, frame count retained, no more reads
    wait_rd("en read");
    step();
    enable = 1'b0;
    step();
    chk("en s0 i", {5'd0, sym_i}, 8'h01);
    chk("en s0 q", {5'd0, sym_q}, 8'h05);
    step();
    chk("en s1 i", {5'd0, sym_i}, 8'h05);
    chk("en s1 q", {5'd0, sym_q}, 8'h01);
    step();
    chk("en complete", {7'd0, complete}, 8'd1);
    step();
    chk("en after complete", {7'd0, complete}, 8'd0);
    for (int k = 0; k < 3; k++) begin
      chk("en no read", {7'd0, read_enable}, 8'd0);
      chk("en idle", {6'd0, state}, 8'd0);
      step();
    end

    // Reset in the middle of a word
    enable = 1'b1;
    #1;
    wait_rd("mid read");
    step();
    step();
    chk("mid s0 i", {5'd0, sym_i}, 8'h07);
    chk("mid s0 q", {5'd0, sym_q}, 8'h07);
    reset = 1'b1;
    #1;
    chk("mid rst valid", {7'd0, sym_valid}, 8'd0);
    chk("mid rst state", {6'd0, state}, 8'd0);
    chk("mid rst i", {5'd0, sym_i}, 8'd0);
    chk("mid rst avail", {7'd0, available}, 8'd0);
    chk("mid rst rd", {7'd0, read_enable}, 8'd0);
    #2;
    reset = 1'b0;
    #1;
    wait_rd("fresh read");
    step();
    rdempty = 1'b1;  // rising during the word must not disturb it
    step();
    chk("fresh s0 i", {5'd0, sym_i}, 8'h05);
    chk("fresh s0 q", {5'd0, sym_q}, 8'h05);
    step();
    chk("fresh s1 i", {5'd0, sym_i}, 8'h01);
    chk("fresh s1 q", {5'd0, sym_q}, 8'h01);
    step();
    chk("fresh end state", {6'd0, state}, 8'd0);
    chk("fresh no complete", {7'd0, complete}, 8'd0);
    chk("empty no read", {7'd0, read_enable}, 8'd0);
    step();
    chk("empty still no read", {7'd0, read_enable}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
